// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out stage with a valid/ready load handshake.
// It shifts an N-bit word out MSB-first, one bit per clock. The framing flags mark
// valid bits and the last bit of each frame. Back-to-back words are sent with no
// idle cycle between them.
// Optional feature: define PARITY_EN to append one even-parity bit to every frame.
module piso_serializer #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] d,
   input  logic         load_valid,
   output logic         load_ready,
   output logic         sout,
   output logic         sout_valid,
   output logic         sout_last,
   output logic         busy
);

`ifdef PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif
   localparam int            CW       = $clog2(FRAME);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_shreg;
   logic [CW-1:0] r_cnt;
   logic          w_last;
   logic          w_accept;
`ifdef PARITY_EN
   logic          r_par;
`endif

   // Final bit of the frame. A new word can be taken here so the next frame follows with no gap.
   assign w_last     = (r_state == SHIFT) && (r_cnt == LAST_CNT);
   assign load_ready = rst & ((r_state == IDLE) | w_last);
   assign w_accept   = load_valid & load_ready;

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: use non-blocking assignments for all clocked state. Every flop then samples pre-edge values, with no ordering races between blocks.
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next-state logic and combinational outputs decoded from the registers.
   always_comb begin
      // NOTE: assign every output a default first. Then no path leaves a signal unassigned, and no latch is inferred.
      w_state_nxt = r_state;
      sout        = 1'b0;
      sout_valid  = 1'b0;
      sout_last   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            sout_valid = 1'b1;
            busy       = 1'b1;
            sout_last  = w_last;
            sout       = r_shreg[N-1];
`ifdef PARITY_EN
            if (r_cnt == CW'(N)) sout = r_par;
`endif
            if (w_last && !w_accept) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: capture on accept, otherwise shift left with zero fill while a frame is active.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shreg <= '0;
         r_cnt   <= '0;
`ifdef PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_shreg <= d;
         r_cnt   <= '0;
`ifdef PARITY_EN
         r_par   <= ^d;
`endif
      end else if (r_state == SHIFT) begin
         r_shreg <= r_shreg << 1;
         if (w_last) r_cnt <= '0;
         else        r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed tests for piso_serializer with N=4.
// Each cycle the bench compares the packed observation {sout_valid, busy, sout, sout_last, load_ready}.
// Build with PARITY_EN defined to cover the parity frame format.
module tb_piso_serializer;
   localparam int N = 4;
`ifdef PARITY_EN
   localparam int FRAME = N + 1;
`else
   localparam int FRAME = N;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] d;
   logic         load_valid;
   logic         load_ready;
   logic         sout;
   logic         sout_valid;
   logic         sout_last;
   logic         busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   piso_serializer #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .sout_last  (sout_last),
      .busy       (busy)
   );

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      rst = 1'b0; load_valid = 1'b0; d = '0;
      #3;
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL reset_async got=%b exp=%b", obs, 5'b00000); end
      tick(); tick();
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL reset_held got=%b exp=%b", obs, 5'b00000); end
      rst = 1'b1;
      #1;
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00001) begin bad++; $display("FAIL reset_release got=%b exp=%b", obs, 5'b00001); end
   endtask

   task automatic test_idle();
      logic [4:0] obs;
      load_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== 5'b00001) begin bad++; $display("FAIL idle_%0d got=%b exp=%b", i, obs, 5'b00001); end
      end
   endtask

   task automatic test_single();
      logic [4:0]       obs, exp;
      logic [FRAME-1:0] seq;
`ifdef PARITY_EN
      seq = 5'b0011_0;
`else
      seq = 4'b0011;
`endif
      d = 4'b0011; load_valid = 1'b1;
      tick();
      load_valid = 1'b0; d = 4'b1111;   // later d changes must not affect the frame
      for (int i = 0; i < FRAME; i++) begin
         exp = {1'b1, 1'b1, seq[FRAME-1-i], i == FRAME-1, i == FRAME-1};
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL single_bit%0d got=%b exp=%b", i, obs, exp); end
         tick();
      end
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00001) begin bad++; $display("FAIL single_idle got=%b exp=%b", obs, 5'b00001); end
   endtask

   task automatic test_back_to_back();
      logic [4:0]         obs, exp;
      logic [2*FRAME-1:0] seq;
      int                 pos;
`ifdef PARITY_EN
      seq = 10'b0110_0_1110_1;
`else
      seq = 8'b0110_1110;
`endif
      d = 4'b0110; load_valid = 1'b1;
      tick();
      d = 4'b1110;                       // held valid until load_ready rises on the last bit
      for (int j = 0; j < 2*FRAME; j++) begin
         pos = j % FRAME;
         exp = {1'b1, 1'b1, seq[2*FRAME-1-j], pos == FRAME-1, pos == FRAME-1};
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL b2b_bit%0d got=%b exp=%b", j, obs, exp); end
         if (j >= FRAME) load_valid = 1'b0;
         tick();
      end
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00001) begin bad++; $display("FAIL b2b_idle got=%b exp=%b", obs, 5'b00001); end
   endtask

   task automatic test_mid_frame_ignore();
      logic [4:0]       obs, exp;
      logic [FRAME-1:0] seq;
`ifdef PARITY_EN
      seq = 5'b0101_0;
`else
      seq = 4'b0101;
`endif
      d = 4'b0101; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         exp = {1'b1, 1'b1, seq[FRAME-1-i], i == FRAME-1, i == FRAME-1};
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL ignore_bit%0d got=%b exp=%b", i, obs, exp); end
         if (i == 1) begin d = 4'b1000; load_valid = 1'b1; end
         else        load_valid = 1'b0;
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== 5'b00001) begin bad++; $display("FAIL ignore_idle%0d got=%b exp=%b", k, obs, 5'b00001); end
         tick();
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [4:0]       obs, exp;
      logic [FRAME-1:0] seq;
`ifdef PARITY_EN
      seq = 5'b0011_0;
`else
      seq = 4'b0011;
`endif
      d = 4'b1110; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL rstmid_pre%0d got=%b exp=%b", i, obs, exp); end
         tick();
      end
      #2;
      rst = 1'b0;                        // asserted between clock edges
      #1;
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00000) begin bad++; $display("FAIL rstmid_abort got=%b exp=%b", obs, 5'b00000); end
      tick();
      rst = 1'b1;
      #1;
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00001) begin bad++; $display("FAIL rstmid_release got=%b exp=%b", obs, 5'b00001); end
      tick();
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00001) begin bad++; $display("FAIL rstmid_noresidue got=%b exp=%b", obs, 5'b00001); end
      d = 4'b0011; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         exp = {1'b1, 1'b1, seq[FRAME-1-i], i == FRAME-1, i == FRAME-1};
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL rstmid_next_bit%0d got=%b exp=%b", i, obs, exp); end
         tick();
      end
   endtask

   task automatic test_frame_1110();
      logic [4:0]       obs, exp;
      logic [FRAME-1:0] seq;
`ifdef PARITY_EN
      seq = 5'b1110_1;
`else
      seq = 4'b1110;
`endif
      d = 4'b1110; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < FRAME; i++) begin
         exp = {1'b1, 1'b1, seq[FRAME-1-i], i == FRAME-1, i == FRAME-1};
         obs = {sout_valid, busy, sout, sout_last, load_ready};
         total++;
         if (obs !== exp) begin bad++; $display("FAIL frame1110_bit%0d got=%b exp=%b", i, obs, exp); end
         tick();
      end
      obs = {sout_valid, busy, sout, sout_last, load_ready};
      total++;
      if (obs !== 5'b00001) begin bad++; $display("FAIL frame1110_idle got=%b exp=%b", obs, 5'b00001); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_mid_frame_ignore();
      test_reset_mid_frame();
      test_frame_1110();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
